// File: rtl/rst_pkg.sv
// Shared types and elaboration helpers for the stage-reset release sequencer.
package rst_pkg;

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        WAIT_DLY = 3'd1,
        WAIT_ACK = 3'd2,
        DONE     = 3'd3,
        ERR      = 3'd4
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Stage index width; a single stage still needs one bit to carry the index.
    function automatic int stg_w(input int nstg);
        return max2(1, clog2(nstg));
    endfunction

    function automatic bit params_ok(input int nstg, input int dly, input int tout);
        return (nstg >= 1) && (nstg <= 16) && (dly >= 1) && (tout >= 1);
    endfunction

endpackage

// File: rtl/rst_release_seq_if.sv
// Stage-reset bus between the release sequencer (master) and the subsystems it gates (slave).
interface rst_release_seq_if
    import rst_pkg::*;
#(
    parameter int NSTG = 4
) ();
    localparam int SW = stg_w(NSTG);

    logic            rsti;
    logic [NSTG-1:0] ack;
    logic [NSTG-1:0] rst_o;
    logic [SW-1:0]   stg_o;
    logic            ready;
    logic            err;

    modport master (
        input  rsti,
        input  ack,
        output rst_o,
        output stg_o,
        output ready,
        output err
    );

    modport slave (
        output rsti,
        output ack,
        input  rst_o,
        input  stg_o,
        input  ready,
        input  err
    );
endinterface

// File: rtl/rst_tmr.sv
// Loadable up-counter with clear, enable and a terminal-count flag against a caller-supplied limit.
module rst_tmr #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          srst_n,
    input  logic          clr,
    input  logic          en,
    input  logic          ld,
    input  logic [CW-1:0] ld_val,
    input  logic [CW-1:0] lim,
    output logic          tc
);
    logic [CW-1:0] cnt_r;

    // Count register: clear beats load beats increment.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (ld) begin
            cnt_r <= ld_val;
        end else if (en) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == lim);
endmodule

// File: rtl/rst_release_seq.sv
// Releases subsystem resets one stage at a time after the upstream reset drops,
// waiting a settle delay and then the stage's init-done before moving on.
module rst_release_seq
    import rst_pkg::*;
#(
    parameter int NSTG = 4,
    parameter int DLY  = 16,
    parameter int TOUT = 1024
) (
    input  logic clk,
    input  logic srst_n,
    rst_release_seq_if.master bus
);
    localparam int SW = stg_w(NSTG);
    localparam int CW = clog2(max2(DLY, TOUT) + 1);
    localparam logic [CW-1:0] DLY_LIM  = CW'(DLY - 1);
    localparam logic [CW-1:0] TOUT_LIM = CW'(TOUT - 1);
    localparam logic [SW-1:0] LAST_STG = SW'(NSTG - 1);

    generate
        if (!params_ok(NSTG, DLY, TOUT)) begin : g_bad_params
            $error("rst_release_seq: NSTG must be 1..16, DLY and TOUT must be >= 1");
        end
    endgenerate

    state_e          state_r;
    logic [NSTG-1:0] rst_r;
    logic [SW-1:0]   stg_r;
    logic            ready_r;
    logic            err_r;

    logic            ack_s;
    logic            tc_s;
    logic            cnt_clr_s;
    logic            cnt_en_s;
    logic [CW-1:0]   lim_s;

    assign ack_s = bus.ack[stg_r];

    // Timer control: one counter serves both waits, its limit follows the state.
    always_comb begin
        cnt_clr_s = 1'b1;
        cnt_en_s  = 1'b0;
        lim_s     = TOUT_LIM;
        case (state_r)
            WAIT_DLY: begin
                lim_s     = DLY_LIM;
                cnt_en_s  = 1'b1;
                cnt_clr_s = bus.rsti | tc_s;
            end
            WAIT_ACK: begin
                lim_s     = TOUT_LIM;
                cnt_en_s  = 1'b1;
                cnt_clr_s = bus.rsti | ack_s | tc_s;
            end
            default: begin
                lim_s     = TOUT_LIM;
                cnt_en_s  = 1'b0;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    rst_tmr #(
        .CW (CW)
    ) u_tmr (
        .clk    (clk),
        .srst_n (srst_n),
        .clr    (cnt_clr_s),
        .en     (cnt_en_s),
        .ld     (1'b0),
        .ld_val ({CW{1'b0}}),
        .lim    (lim_s),
        .tc     (tc_s)
    );

    // Sequencer FSM with registered outputs; an upstream reset aborts any sequence in flight.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_r <= HOLD;
            rst_r   <= {NSTG{1'b1}};
            stg_r   <= {SW{1'b0}};
            ready_r <= 1'b0;
            err_r   <= 1'b0;
        end else if (bus.rsti && (state_r != HOLD)) begin
            state_r <= HOLD;
            rst_r   <= {NSTG{1'b1}};
            stg_r   <= {SW{1'b0}};
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                HOLD: begin
                    rst_r   <= {NSTG{1'b1}};
                    ready_r <= 1'b0;
                    stg_r   <= {SW{1'b0}};
                    if (!bus.rsti) begin
                        state_r <= WAIT_DLY;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                WAIT_DLY: begin
                    if (tc_s) begin
                        rst_r[stg_r] <= 1'b0;
                        state_r      <= WAIT_ACK;
                    end else begin
                        state_r      <= WAIT_DLY;
                    end
                end
                WAIT_ACK: begin
                    // An ack on the final timeout cycle still counts as success.
                    if (ack_s) begin
                        if (stg_r == LAST_STG) begin
                            state_r <= DONE;
                            ready_r <= 1'b1;
                        end else begin
                            stg_r   <= stg_r + SW'(1);
                            state_r <= WAIT_DLY;
                        end
                    end else if (tc_s) begin
                        state_r <= ERR;
                        err_r   <= 1'b1;
                        rst_r   <= {NSTG{1'b1}};
                        ready_r <= 1'b0;
                    end else begin
                        state_r <= WAIT_ACK;
                    end
                end
                DONE: begin
                    ready_r <= 1'b1;
                    rst_r   <= {NSTG{1'b0}};
                end
                ERR: begin
                    rst_r   <= {NSTG{1'b1}};
                    err_r   <= 1'b1;
                    ready_r <= 1'b0;
                end
                default: begin
                    state_r <= HOLD;
                    rst_r   <= {NSTG{1'b1}};
                    stg_r   <= {SW{1'b0}};
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rst_o = rst_r;
    assign bus.stg_o = stg_r;
    assign bus.ready = ready_r;
    assign bus.err   = err_r;
endmodule
